veerwolf_sevenseg: RTL and testbench

VEERWOLF_SEVENSEG -- requirements
Module: veerwolf_sevenseg

---
 rtl/veerwolf_sevenseg.sv | 118 +++++++++++
 tb/tb_veerwolf_sevenseg.sv | 130 +++++++++++++
 2 files changed

// File: rtl/veerwolf_sevenseg.sv
// Four-digit multiplexed hex display driver: registered outputs, one cycle behind the scan state.
// Each digit gets a blanking gap before its lit slot; inputs are snapshotted once per scan to avoid tearing.
module veerwolf_sevenseg #(
  parameter int ON_CYCLES    = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_en,
  input  logic [3:0]  i_dp,
  output logic [6:0]  o_seg_n,
  output logic        o_dp_n,
  output logic [3:0]  o_an_n
);

  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, ON} state_t;

  state_t        state, state_nxt;
  logic [1:0]    digit, digit_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   value_q;
  logic [3:0]    en_q, dp_q;
  logic          load;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
  logic [3:0]    an_nxt;

  assign load = (state == BLANK) && (digit == 2'd0) && (cnt == '0);
  assign nib  = value_q[{digit, 2'b00} +: 4];

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    cnt_nxt   = cnt + 1'b1;
    if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        cnt_nxt   = '0;
        state_nxt = ON;
      end
    end else begin
      if (cnt == ON_LAST) begin
        cnt_nxt   = '0;
        state_nxt = BLANK;
        digit_nxt = digit + 2'd1;
      end
    end
  end

  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  // Disabled digits keep their timing slot but leave every anode off.
  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (state == ON) begin
      seg_nxt = glyph;
      dp_nxt  = ~dp_q[digit];
      if (en_q[digit]) an_nxt = ~(4'b0001 << digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BLANK;
      digit   <= 2'd0;
      cnt     <= '0;
      value_q <= 16'h0000;
      en_q    <= 4'h0;
      dp_q    <= 4'h0;
      o_an_n  <= 4'hF;
      o_seg_n <= 7'h7F;
      o_dp_n  <= 1'b1;
    end else begin
      state   <= state_nxt;
      digit   <= digit_nxt;
      cnt     <= cnt_nxt;
      o_an_n  <= an_nxt;
      o_seg_n <= seg_nxt;
      o_dp_n  <= dp_nxt;
      if (load) begin
        value_q <= i_value;
        en_q    <= i_en;
        dp_q    <= i_dp;
      end
    end
  end

endmodule

// File: tb/tb_veerwolf_sevenseg.sv
// Bench for veerwolf_sevenseg: directed scenarios then random traffic, checked against a slot-arithmetic model.
module tb_veerwolf_sevenseg;
  localparam int ON  = 4;
  localparam int BL  = 2;
  localparam int SLOT = ON + BL;
  localparam int PER  = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_value;
  logic [3:0]  i_en, i_dp;
  logic [6:0]  o_seg_n;
  logic        o_dp_n;
  logic [3:0]  o_an_n;

  veerwolf_sevenseg #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .i_value(i_value), .i_en(i_en), .i_dp(i_dp),
    .o_seg_n(o_seg_n), .o_dp_n(o_dp_n), .o_an_n(o_an_n)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: position within the scan since the last reset, plus the captured snapshot.
  int          pos = 0;
  logic [15:0] s_val = '0;
  logic [3:0]  s_en = '0, s_dp = '0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  int          cyc = 0;
  int          last_d0 = -1;
  logic [3:0]  prev_an = 4'hF;

  task automatic step();
    int slot, w;
    @(posedge clk);
    cyc++;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      s_val = '0; s_en = '0; s_dp = '0;
      pos = 0;
      last_d0 = -1;
    end else begin
      slot = pos / SLOT;
      w    = pos % SLOT;
      if (w < BL) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = s_en[slot] ? ~(4'b0001 << slot) : 4'hF;
        e_seg = glyphs[s_val[slot*4 +: 4]];
        e_dp  = ~s_dp[slot];
      end
      if (pos == 0) begin
        s_val = i_value; s_en = i_en; s_dp = i_dp;
      end
      pos = (pos + 1) % PER;
    end
    #1;
    chk("an", 32'(o_an_n), 32'(e_an));
    chk("seg", 32'(o_seg_n), 32'(e_seg));
    chk("dp", 32'(o_dp_n), 32'(e_dp));
    chk("onehot_an", 32'($countones(~o_an_n) <= 1), 32'd1);
    if (prev_an[0] && !o_an_n[0]) begin
      if (last_d0 >= 0) chk("d0_period", 32'(cyc - last_d0), 32'(PER));
      last_d0 = cyc;
    end
    if (!e_an[0] == 1'b0 && e_en0_off()) last_d0 = -1;
    prev_an = o_an_n;
  endtask

  // A disabled digit-0 slot breaks the period chain; restart measurement.
  function automatic bit e_en0_off();
    return (pos == BL + 1) && !s_en[0];
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; i_value = 16'h1234; i_en = 4'hF; i_dp = 4'h0;
    run(3);
    chk("reset_an", 32'(o_an_n), 32'hF);
    chk("reset_seg", 32'(o_seg_n), 32'h7F);
    rst = 1'b0;
    run(PER + 2 * SLOT + BL + 1);
    i_value = 16'hABCD;
    run(2 * PER);
    i_value = 16'h8888; i_en = 4'b0101; i_dp = 4'b0001;
    run(2 * PER);
    i_en = 4'hF;
    run(PER + SLOT + BL + 1);
    rst = 1'b1;
    run(1);
    chk("midrst_an", 32'(o_an_n), 32'hF);
    chk("midrst_seg", 32'(o_seg_n), 32'h7F);
    rst = 1'b0;
    run(PER);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) i_value = 16'($urandom);
      if ($urandom_range(0, 19) == 0) i_en = 4'($urandom);
      if ($urandom_range(0, 19) == 0) i_dp = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      if (i_en[0] == 1'b0) last_d0 = -1;
      step();
    end
    rst = 1'b0;
    run(PER);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end
endmodule
